// File: rtl/lpc_io_target_pkg.sv
// Shared LPC I/O target definitions: register offsets, STATUS/CTRL bit positions,
// FSM state encodings and the value returned for unmapped reads.
package lpc_io_target_pkg;

    localparam logic [1:0] OFS_SCRATCH = 2'd0;
    localparam logic [1:0] OFS_STATUS  = 2'd1;
    localparam logic [1:0] OFS_CTRL    = 2'd2;
    localparam logic [1:0] OFS_MBOX    = 2'd3;

    localparam int STAT_OVF     = 7;
    localparam int STAT_FULL    = 6;
    localparam int STAT_EMPTY   = 5;
    localparam int CTRL_IRQ_EN  = 7;
    localparam int CTRL_OVF_CLR = 6;

    localparam logic [7:0] RD_UNMAPPED = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_ACK  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_ACK  = 2'd3
    } lpc_state_e;

    // STATUS only has five bits for the FIFO count, so larger counts pin at 31.
    function automatic logic [4:0] sat_count(input logic [8:0] c);
        return (c > 9'd31) ? 5'd31 : c[4:0];
    endfunction

endpackage

// File: rtl/lpc_sync_fifo.sv
// Small synchronous FIFO with push/pop/full/empty/count and synchronous active-low reset.
// A push while full is accepted only when a pop happens in the same cycle.
// The head reads 0 while the FIFO is empty.
module lpc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   nrst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = empty_o ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is not reset; the empty gating on dout_o hides stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/lpc_io_target.sv
// LPC I/O target: 4-byte register window, port-80 POST capture and mailbox
// behind the LPC peripheral's write-strobe / read-request handshake.
// Optional feature macro: LPC_IO_TARGET_PORT80_EN (POST FIFO and port-80 decode).
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for a write strobe or a read-request rising edge
// ST_WR_ACK  | write done, holding wr_done until the strobe drops
// ST_RD_WAIT | counting down RD_WAIT clocks before presenting data
// ST_RD_ACK  | holding data_rd/data until the request drops
module lpc_io_target
    import lpc_io_target_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'h0E00,
    parameter logic [15:0] PORT80_ADDR = 16'h0080,
    parameter int          FIFO_DEPTH  = 16,
    parameter int          RD_WAIT     = 2
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic [15:0] lpc_addr_i,
    input  logic [7:0]  lpc_data_i,
    input  logic        lpc_data_wr_i,
    output logic        lpc_wr_done_o,
    input  logic        lpc_data_req_i,
    output logic        lpc_data_rd_o,
    output logic [7:0]  lpc_data_o,
    output logic [3:0]  irq_num_o,
    output logic        interrupt_o,
    input  logic [7:0]  dev_data_i,
    input  logic        dev_valid_i,
    output logic        dev_full_o,
    output logic [7:0]  post_code_o,
    output logic        post_valid_o,
    input  logic        post_pop_i
);
    if (PORT80_ADDR[15:2] == BASE_ADDR[15:2]) begin : g_bad_map
        $error("lpc_io_target: PORT80_ADDR overlaps the BASE_ADDR window");
    end
    if (RD_WAIT < 0 || RD_WAIT > 15) begin : g_bad_wait
        $error("lpc_io_target: RD_WAIT must be 0..15");
    end

    lpc_state_e state;
    logic [3:0] wait_cnt;
    logic       req_q;
    logic       rd_is_mbox;
    logic [7:0] scratch;
    logic       irq_en;
    logic [3:0] irq_num;
    logic [7:0] mbox;
    logic       dev_full;
    logic [7:0] port80_q;
    logic [7:0] status;
    logic [7:0] rd_val;
    logic       win_hit;
    logic       p80_hit;
    logic       wr_fire;
    logic       wr_ctrl;
    logic       mbox_clr;

    assign win_hit  = (lpc_addr_i[15:2] == BASE_ADDR[15:2]);
    assign wr_fire  = (state == ST_IDLE) && lpc_data_wr_i;
    assign wr_ctrl  = wr_fire && win_hit && (lpc_addr_i[1:0] == OFS_CTRL);
    assign mbox_clr = (state == ST_RD_ACK) && !lpc_data_req_i && rd_is_mbox;

    assign irq_num_o  = irq_num;
    assign dev_full_o = dev_full;

`ifdef LPC_IO_TARGET_PORT80_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          overflow;

    assign p80_hit      = (lpc_addr_i == PORT80_ADDR);
    assign fifo_push    = wr_fire && p80_hit;
    assign post_valid_o = !fifo_empty;

    lpc_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_post_fifo (
        .clk_i   (clk_i),
        .nrst_i  (nrst_i),
        .push_i  (fifo_push),
        .din_i   (lpc_data_i),
        .pop_i   (post_pop_i),
        .dout_o  (post_code_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Last POST byte for read-back, and the sticky overflow flag (a new overflow beats a clear).
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            port80_q <= '0;
            overflow <= 1'b0;
        end else begin
            if (fifo_push) port80_q <= lpc_data_i;
            if (fifo_push && fifo_full && !post_pop_i) overflow <= 1'b1;
            else if (wr_ctrl && lpc_data_i[CTRL_OVF_CLR]) overflow <= 1'b0;
        end
    end

    always_comb begin
        status                       = '0;
        status[STAT_OVF]             = overflow;
        status[STAT_FULL]            = dev_full;
        status[STAT_EMPTY]           = fifo_empty;
        status[4:0]                  = sat_count(9'(fifo_count));
    end
`else
    logic unused_cfg;

    assign unused_cfg   = post_pop_i ^ (FIFO_DEPTH == 0);
    assign p80_hit      = 1'b0;
    assign port80_q     = '0;
    assign post_code_o  = '0;
    assign post_valid_o = 1'b0;

    always_comb begin
        status             = '0;
        status[STAT_FULL]  = dev_full;
        status[STAT_EMPTY] = 1'b1;
    end
`endif

    // Read mux for the currently addressed register.
    always_comb begin
        rd_val = RD_UNMAPPED;
        if (win_hit) begin
            case (lpc_addr_i[1:0])
                OFS_SCRATCH: rd_val = scratch;
                OFS_STATUS:  rd_val = status;
                OFS_CTRL:    rd_val = {irq_en, 3'b000, irq_num};
                OFS_MBOX:    rd_val = mbox;
                default:     rd_val = RD_UNMAPPED;
            endcase
        end else if (p80_hit) begin
            rd_val = port80_q;
        end
    end

    // Handshake FSM; a write strobe in IDLE takes priority over a request edge.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            req_q         <= 1'b0;
            rd_is_mbox    <= 1'b0;
            lpc_wr_done_o <= 1'b0;
            lpc_data_rd_o <= 1'b0;
            lpc_data_o    <= RD_UNMAPPED;
        end else begin
            req_q <= lpc_data_req_i;
            case (state)
                ST_IDLE: begin
                    if (lpc_data_wr_i) begin
                        lpc_wr_done_o <= 1'b1;
                        state         <= ST_WR_ACK;
                    end else if (lpc_data_req_i && !req_q) begin
                        wait_cnt <= 4'(RD_WAIT);
                        state    <= ST_RD_WAIT;
                    end
                end
                ST_WR_ACK: begin
                    if (!lpc_data_wr_i) begin
                        lpc_wr_done_o <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                ST_RD_WAIT: begin
                    if (!lpc_data_req_i) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == '0) begin
                        lpc_data_o    <= rd_val;
                        lpc_data_rd_o <= 1'b1;
                        rd_is_mbox    <= win_hit && (lpc_addr_i[1:0] == OFS_MBOX);
                        state         <= ST_RD_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_RD_ACK: begin
                    if (!lpc_data_req_i) begin
                        lpc_data_rd_o <= 1'b0;
                        rd_is_mbox    <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Register file, mailbox and registered interrupt; a new mailbox byte beats the read clear.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            scratch     <= '0;
            irq_en      <= 1'b0;
            irq_num     <= '0;
            mbox        <= '0;
            dev_full    <= 1'b0;
            interrupt_o <= 1'b0;
        end else begin
            if (wr_fire && win_hit && (lpc_addr_i[1:0] == OFS_SCRATCH)) scratch <= lpc_data_i;
            if (wr_ctrl) begin
                irq_en  <= lpc_data_i[CTRL_IRQ_EN];
                irq_num <= lpc_data_i[3:0];
            end
            if (dev_valid_i) begin
                mbox     <= dev_data_i;
                dev_full <= 1'b1;
            end else if (mbox_clr) begin
                dev_full <= 1'b0;
            end
            interrupt_o <= irq_en & dev_full;
        end
    end

endmodule

// File: doc/lpc_io_target.md
Name: lpc_io_target

Overview:
- Data-provider stage directly downstream of the LPC peripheral FSM.
- Consumes its write strobe, address and data.
- Answers its read requests using the wr_done / data_rd handshake.
- Decodes a 4-byte register window plus the port-80 POST code, buffers POST codes in a FIFO for local logic, and drives the interrupt/IRQ-number inputs back to the peripheral.

Parameters:
BASE_ADDR, 16'h0E00, I/O base of the 4-register window (low 2 bits ignored)
PORT80_ADDR, 16'h0080, POST code port address
FIFO_DEPTH, 16, POST FIFO entries (power of 2, 2..256)
RD_WAIT, 2, extra clocks between read request detection and data_rd (0..15)

Ports:
clk_i  in  1  LPC clock, all logic on posedge
nrst_i  in  1  synchronous active-low reset
lpc_addr_i  in  16  address from peripheral
lpc_data_i  in  8  write data from peripheral
lpc_data_wr_i  in  1  write strobe (level, held until wr_done seen)
lpc_wr_done_o  out  1  write accepted
lpc_data_req_i  in  1  read request (rising = request, falling = consumed/abort)
lpc_data_rd_o  out  1  read data valid
lpc_data_o  out  8  read data
irq_num_o  out  4  SERIRQ slot number (CTRL[3:0])
interrupt_o  out  1  active-high interrupt request
dev_data_i  in  8  device-to-host mailbox byte
dev_valid_i  in  1  mailbox write strobe (single cycle)
dev_full_o  out  1  mailbox holds unread byte
post_code_o  out  8  FIFO head
post_valid_o  out  1  FIFO not empty
post_pop_i  in  1  pop FIFO head

Behaviour:
- Reset (nrst_i low at posedge): all outputs 0, lpc_data_o 8'hFF, FSM IDLE, FIFO empty, SCRATCH=0, CTRL=0, mailbox empty, overflow=0.
- Register map, offset = lpc_addr_i - BASE_ADDR:
  - +0 SCRATCH: R/W.
  - +1 STATUS: RO. [7]=overflow, [6]=dev_full, [5]=fifo_empty, [4:0]=fifo count saturated at 31.
  - +2 CTRL: R/W. [7]=irq_en, [6]=ovf_clr (write-1 clears overflow, reads 0), [3:0]=irq_num.
  - +3 MBOX: RO. A read returns the byte and clears dev_full on data_rd handshake completion.
  - PORT80_ADDR: a write pushes to FIFO; a read returns the last byte written there (0 after reset).
- Unmapped write: acknowledged, discarded. Unmapped read: returns 8'hFF, acknowledged.
- FSM states:
  - IDLE.
  - WR_ACK.
  - RD_WAIT.
  - RD_ACK.
- IDLE:
  - lpc_data_wr_i high → perform write this cycle, assert wr_done next cycle, go WR_ACK.
  - Rising edge of lpc_data_req_i (registered previous value) → go RD_WAIT with counter=RD_WAIT.
  - Both write and request edge in the same cycle → write wins; the request is lost (peripheral never issues both).
- WR_ACK: hold wr_done high until lpc_data_wr_i low, then drop wr_done the same edge and return to IDLE. Each write takes effect exactly once.
- RD_WAIT: decrement counter. At 0, sample the selected register into lpc_data_o, assert data_rd, go RD_ACK.
  - RD_WAIT=0 → data_rd asserts 1 clock after the request edge.
  - lpc_data_req_i falls while in RD_WAIT (LFRAME abort) → IDLE, no side effects.
- RD_ACK: hold data_rd high and lpc_data_o stable until lpc_data_req_i low, then clear data_rd and return to IDLE. Read side effects (MBOX clear) apply at this exit.
- FIFO:
  - Push while full → byte dropped, overflow set (sticky).
  - Push and pop in the same cycle when full → both succeed.
  - Pop when empty → ignored.
  - Count width = clog2(FIFO_DEPTH)+1.
- Mailbox: dev_valid_i overwrites the byte and sets dev_full. If dev_valid_i coincides with the MBOX read completion, the new byte wins and dev_full stays 1.
- interrupt_o = CTRL[7] & dev_full, registered (1-clock latency).
- irq_num_o = CTRL[3:0] directly.
- Address compare uses the full 16 bits. BASE_ADDR window and PORT80_ADDR must not overlap (elaboration check).

Optional Feature:
- LPC_IO_TARGET_PORT80_EN defined: POST FIFO, port-80 decode, post_* outputs and STATUS[7],[5:0] as above.
- Undefined: no FIFO instantiated.
  - PORT80_ADDR is treated as unmapped.
  - post_code_o=0, post_valid_o=0, post_pop_i ignored.
  - STATUS[7]=0, [5]=1, [4:0]=0.

Decomposition:
- Shared defines file (alongside existing LPC defines): register offsets, STATUS/CTRL bit positions, FSM state encodings, unmapped read value 8'hFF.
- One sub-module: lpc_sync_fifo (parameterised width/depth, push/pop/full/empty/count, synchronous active-low reset), reusable elsewhere.

Test Plan:
- Write 8'hA5 to BASE+0 with wr held until wr_done → wr_done high 1 clk after strobe, drops same clk strobe drops; read BASE+0 returns 8'hA5, data_rd at RD_WAIT+1 clocks after req edge.
- Write 17 POST codes 0x01..0x11 to 0x80 (depth 16) → STATUS=8'h90; post_code_o=0x01; pop 16 → post_valid_o 0; write CTRL=8'h40 → overflow cleared.
- dev_valid_i with 0x3C, CTRL=8'h85 → dev_full, interrupt_o 1 next clk, irq_num_o=5; read BASE+3 returns 0x3C, interrupt_o 0 after handshake ends.
- Read request dropped during RD_WAIT (RD_WAIT=4) → no data_rd, mailbox stays full, FSM IDLE next clk.
- Read 0x1234 (unmapped) → 8'hFF with normal handshake; write to it → acked, no register changes.
- Assert nrst_i low during RD_ACK → next clk data_rd=0, wr_done=0, FIFO empty, CTRL=0.
